instruction_fetch_unit: RTL and testbench

//  Requester side of the instruction-memory read interface: owns the PC, drives

---
 rtl/instruction_fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, requests words from instruction memory and holds them in IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_count / stall_count outputs.
module instruction_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_addr,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   imem_ready,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic                   if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            stall_count
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(3'd4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(2'd3);

  state_t                 state_r;
  state_t                 state_s;
  logic [PC_WIDTH-1:0]    pc_r;
  logic [PC_WIDTH-1:0]    pc_s;
  logic [PC_WIDTH-1:0]    pc_inc_s;
  logic [PC_WIDTH-1:0]    target_s;
  logic [PC_WIDTH-1:0]    if_pc_r;
  logic [PC_WIDTH-1:0]    if_pc_s;
  logic [INSTR_WIDTH-1:0] if_instr_r;
  logic [INSTR_WIDTH-1:0] if_instr_s;
  logic                   if_valid_r;
  logic                   if_valid_s;
  logic                   req_r;

  // Redirect targets are forced word aligned; increment wraps modulo 2^PC_WIDTH.
  assign target_s = branch_addr & ALIGN_MASK;
  assign pc_inc_s = pc_r + PC_STEP;

  // Next-state, next-PC and IF/ID load selection.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    if_pc_s    = if_pc_r;
    if_instr_s = if_instr_r;
    if_valid_s = if_valid_r;
    case (state_r)
      IDLE: begin
        state_s = FETCH;
        if (branch_taken) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        if (freeze) begin
          if_pc_s    = if_pc_r;
          if_instr_s = if_instr_r;
          if_valid_s = if_valid_r;
        end else begin
          if_pc_s    = {PC_WIDTH{1'b0}};
          if_instr_s = {INSTR_WIDTH{1'b0}};
          if_valid_s = 1'b0;
        end
      end
      FETCH: begin
        if (branch_taken) begin
          // Redirect beats freeze and drops any response arriving this cycle.
          state_s    = IDLE;
          pc_s       = target_s;
          if_pc_s    = {PC_WIDTH{1'b0}};
          if_instr_s = {INSTR_WIDTH{1'b0}};
          if_valid_s = 1'b0;
        end else if (freeze) begin
          state_s    = FETCH;
          pc_s       = pc_r;
          if_pc_s    = if_pc_r;
          if_instr_s = if_instr_r;
          if_valid_s = if_valid_r;
        end else if (imem_ready) begin
          state_s    = FETCH;
          pc_s       = pc_inc_s;
          if_pc_s    = pc_inc_s;
          if_instr_s = imem_instr;
          if_valid_s = 1'b1;
        end else begin
          // Wait state: bubble so decode never sees the same word twice.
          state_s    = FETCH;
          pc_s       = pc_r;
          if_pc_s    = {PC_WIDTH{1'b0}};
          if_instr_s = {INSTR_WIDTH{1'b0}};
          if_valid_s = 1'b0;
        end
      end
      default: begin
        state_s    = IDLE;
        pc_s       = pc_r;
        if_pc_s    = {PC_WIDTH{1'b0}};
        if_instr_s = {INSTR_WIDTH{1'b0}};
        if_valid_s = 1'b0;
      end
    endcase
  end

  // State, PC, request flag and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      if_pc_r    <= {PC_WIDTH{1'b0}};
      if_instr_r <= {INSTR_WIDTH{1'b0}};
      if_valid_r <= 1'b0;
      req_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      if_pc_r    <= if_pc_s;
      if_instr_r <= if_instr_s;
      if_valid_r <= if_valid_s;
      req_r      <= (state_s == FETCH);
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = pc_r;
  assign if_pc     = if_pc_r;
  assign if_instr  = if_instr_r;
  assign if_valid  = if_valid_r;

`ifdef FETCH_PERF_CNT_EN
  logic        accept_s;
  logic        stall_s;
  logic [31:0] fetch_count_r;
  logic [31:0] stall_count_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

  // Classify each FETCH cycle as an accepted word or a stall.
  always_comb begin
    accept_s = 1'b0;
    stall_s  = 1'b0;
    if ((state_r == FETCH) && !branch_taken) begin
      accept_s = !freeze && imem_ready;
      stall_s  = freeze || !imem_ready;
    end else begin
      accept_s = 1'b0;
      stall_s  = 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_r <= 32'd0;
      stall_count_r <= 32'd0;
    end else begin
      if (accept_s) begin
        fetch_count_r <= sat_inc(fetch_count_r);
      end
      if (stall_s) begin
        stall_count_r <= sat_inc(stall_count_r);
      end
    end
  end

  assign fetch_count = fetch_count_r;
  assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios then random traffic vs. a behavioural model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: the PC, whether the unit is issuing requests, the IF/ID contents.
  logic [31:0] m_pc;
  bit          m_fetching;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_instr;
  bit          m_if_valid;
  longint      m_fc;
  longint      m_sc;

  instruction_fetch_unit #(
    .PC_WIDTH   (32),
    .INSTR_WIDTH(32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .imem_ready  (imem_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
  endfunction

  assign imem_instr = word_of(imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_if_pc    = 32'd0;
    m_if_instr = 32'd0;
    m_if_valid = 1'b0;
  endtask

  task automatic model_update(input bit r, input bit fz, input bit br, input logic [31:0] ba, input bit rdy);
    if (r) begin
      m_pc = 32'd0; m_fetching = 1'b0; model_bubble(); m_fc = 0; m_sc = 0;
    end else if (!m_fetching) begin
      if (br) m_pc = {ba[31:2], 2'b00};
      if (!fz) model_bubble();
      m_fetching = 1'b1;
    end else if (br) begin
      m_pc = {ba[31:2], 2'b00}; model_bubble(); m_fetching = 1'b0;
    end else if (fz) begin
      if (m_sc < 64'hFFFF_FFFF) m_sc++;
    end else if (rdy) begin
      m_if_instr = word_of(m_pc);
      m_pc       = m_pc + 32'd4;
      m_if_pc    = m_pc;
      m_if_valid = 1'b1;
      if (m_fc < 64'hFFFF_FFFF) m_fc++;
    end else begin
      model_bubble();
      if (m_sc < 64'hFFFF_FFFF) m_sc++;
    end
  endtask

  task automatic compare_all();
    chk("imem_req",  imem_req,  m_fetching);
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid",  if_valid,  m_if_valid);
    chk("if_instr",  if_instr,  m_if_instr);
    chk("if_pc",     if_pc,     m_if_pc);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_fc);
    chk("stall_count", stall_count, m_sc);
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input bit r, input bit fz, input bit br, input logic [31:0] ba, input bit rdy);
    rst = r; freeze = fz; branch_taken = br; branch_addr = ba; imem_ready = rdy;
    @(posedge clk);
    model_update(r, fz, br, ba, rdy);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0; imem_ready = 1'b1;
    // Reset for two cycles with a zero-wait memory.
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", if_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("dead_slot_valid", if_valid, 1'b0);
    chk("dead_slot_req", imem_req, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("first_valid", if_valid, 1'b1);
    chk("first_pc", if_pc, 32'd4);
    chk("first_instr", if_instr, word_of(32'd0));
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("second_pc", if_pc, 32'd8);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("third_pc", if_pc, 32'd12);
    chk("third_addr", imem_addr, 32'd12);

    // Freeze for three cycles at PC=12.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      chk("frz_addr", imem_addr, 32'd12);
      chk("frz_pc", if_pc, 32'd12);
      chk("frz_instr", if_instr, word_of(32'd8));
    end
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("unfrz_pc", if_pc, 32'd16);
    chk("unfrz_instr", if_instr, word_of(32'd12));
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("pre_br_pc", if_pc, 32'd20);

    // Branch to 0x40 from PC=20.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    chk("br_valid", if_valid, 1'b0);
    chk("br_req", imem_req, 1'b0);
    chk("br_addr", imem_addr, 32'h40);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("br_refetch_req", imem_req, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("br_target_pc", if_pc, 32'h44);
    chk("br_target_instr", if_instr, word_of(32'h40));

    // Branch and freeze together, with a misaligned target.
    step(1'b0, 1'b1, 1'b1, 32'h83, 1'b1);
    chk("brfrz_addr", imem_addr, 32'h80);
    chk("brfrz_valid", if_valid, 1'b0);
    chk("brfrz_instr", if_instr, 32'd0);
    chk("brfrz_pc", if_pc, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("brfrz_next_pc", if_pc, 32'h84);

    // Two wait states at PC=8.
    step(1'b0, 1'b0, 1'b1, 32'h8, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("wait_valid", if_valid, 1'b0);
      chk("wait_instr", if_instr, 32'd0);
      chk("wait_addr", imem_addr, 32'd8);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("wait_done_pc", if_pc, 32'd12);
    chk("wait_done_instr", if_instr, word_of(32'd8));

    // Reset arriving mid-wait at PC=0x1C.
    step(1'b0, 1'b0, 1'b1, 32'h1C, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("midwait_req", imem_req, 1'b1);
    chk("midwait_addr", imem_addr, 32'h1C);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("midrst_req", imem_req, 1'b0);
    chk("midrst_addr", imem_addr, 32'd0);
    chk("midrst_valid", if_valid, 1'b0);
    chk("midrst_instr", if_instr, 32'd0);
    chk("midrst_pc", if_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_fetch_count", fetch_count, 32'd0);
    chk("midrst_stall_count", stall_count, 32'd0);
`endif

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_pc", if_pc, 32'd0);
    chk("wrap_next_addr", imem_addr, 32'd0);
    chk("wrap_instr", if_instr, word_of(32'hFFFF_FFFC));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ba;
      ba = $urandom;
      if ($urandom_range(0, 5) == 0) ba = 32'hFFFF_FFE0 | (ba & 32'h1F);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), ba, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
